// File: rtl/pipe_out_fifo_if.sv
// Bundle between the stallable pipeline, the output FIFO and its consumer.
// Optional almost-full flag is present only when FIFO_ALMOST_FULL_EN is defined.
interface pipe_out_fifo_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 2
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_allow;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [AW:0]      count;
`ifdef FIFO_ALMOST_FULL_EN
    logic             almost_full;

    // Producer/consumer side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_allow, out_valid, out_data, count, almost_full
    );

    // FIFO side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_allow, out_valid, out_data, count, almost_full
    );
`else
    // Producer/consumer side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_allow, out_valid, out_data, count
    );

    // FIFO side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_allow, out_valid, out_data, count
    );
`endif
endinterface

// File: rtl/pipe_out_fifo.sv
// Output buffer downstream of the three-stage stallable pipeline.
// Holds up to DEPTH words in order; in_allow depends only on registered
// occupancy, so consumer stalls never reach the pipeline combinationally.
// Optional feature macro: FIFO_ALMOST_FULL_EN (registered almost_full flag).
module pipe_out_fifo #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AW        = 2,
    parameter int unsigned AF_THRESH = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_out_fifo_if.slave bus
);

    localparam int unsigned CW       = AW + 1;
    localparam logic [AW:0] FULL_LVL = CW'(DEPTH);

    // Reject geometries where the pointers cannot wrap cleanly
    if ((DEPTH != (32'd1 << AW)) || (DEPTH < 32'd2) || (AF_THRESH > DEPTH)) begin : g_cfg_bad
        $error("pipe_out_fifo: inconsistent DEPTH/AW/AF_THRESH");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic [AW:0]      count_next;
    logic             allow_c;
    logic             valid_c;
    logic             push_c;
    logic             pop_c;

    // Handshake qualifiers derived from registered occupancy
    always_comb begin
        allow_c = (count_q != FULL_LVL);
        valid_c = (count_q != CW'(0));
        push_c  = bus.in_valid & allow_c;
        pop_c   = valid_c & bus.out_ready;
    end

    // Occupancy after this edge; push and pop together leave it unchanged
    always_comb begin
        count_next = count_q;
        case ({push_c, pop_c})
            2'b10:   count_next = count_q + CW'(1);
            2'b01:   count_next = count_q - CW'(1);
            default: count_next = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all entries
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_next;
        end
    end

    // Storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (rst_n && push_c) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    localparam logic [AW:0] AF_LVL = CW'(AF_THRESH);
    logic af_q;

    // Early throttle flag tracks the occupancy that will hold after this edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            af_q <= 1'b0;
        end else begin
            af_q <= (count_next >= AF_LVL);
        end
    end

    assign bus.almost_full = af_q;
`endif

    assign bus.in_allow  = allow_c;
    assign bus.out_valid = valid_c;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.count     = count_q;

endmodule

// File: tb/tb_pipe_out_fifo.sv
// Directed vector bench for pipe_out_fifo: a table of per-cycle stimulus with
// expected post-edge state, plus a hand-written full/pop/drain sequence.
module tb_pipe_out_fifo;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 2;

    logic clk;
    logic rst_n;

    pipe_out_fifo_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    pipe_out_fifo #(
        .WIDTH(WIDTH), .DEPTH(4), .AW(AW), .AF_THRESH(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [31:0] d;
        logic        rdy;
        logic [2:0]  cnt;
        logic        ov;
        logic        ia;
        logic        chk_d;
        logic [31:0] od;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;

    task automatic add(input logic r, input logic iv, input logic [31:0] d, input logic rdy,
                       input logic [2:0] cnt, input logic ov, input logic ia,
                       input logic chk_d, input logic [31:0] od);
        vec_t v;
        v.rst_n = r; v.iv = iv; v.d = d; v.rdy = rdy;
        v.cnt = cnt; v.ov = ov; v.ia = ia; v.chk_d = chk_d; v.od = od;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [31:0] d, input logic rdy);
        rst_n        = r;
        bus.in_valid = iv;
        bus.in_data  = d;
        bus.out_ready = rdy;
    endtask

    task automatic check_state(input string tag, input logic [2:0] cnt, input logic ov,
                               input logic ia, input logic chk_d, input logic [31:0] od);
        check({tag, ".count"},     32'(bus.count),     32'(cnt));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        check({tag, ".in_allow"},  32'(bus.in_allow),  32'(ia));
        if (chk_d) check({tag, ".out_data"}, bus.out_data, od);
`ifdef FIFO_ALMOST_FULL_EN
        check({tag, ".almost_full"}, 32'(bus.almost_full), 32'(cnt >= 3'd3));
`endif
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);

        // 1: reset and idle
        add(0, 0, 32'h00, 0, 3'd0, 0, 1, 0, 32'h00);
        add(1, 0, 32'h00, 0, 3'd0, 0, 1, 0, 32'h00);
        // 2: fill, fifth word held upstream
        add(1, 1, 32'hA0, 0, 3'd1, 1, 1, 1, 32'hA0);
        add(1, 1, 32'hA1, 0, 3'd2, 1, 1, 1, 32'hA0);
        add(1, 1, 32'hA2, 0, 3'd3, 1, 1, 1, 32'hA0);
        add(1, 1, 32'hA3, 0, 3'd4, 1, 0, 1, 32'hA0);
        add(1, 1, 32'hA4, 0, 3'd4, 1, 0, 1, 32'hA0);
        // 3: drain in order
        add(1, 0, 32'h00, 1, 3'd3, 1, 1, 1, 32'hA1);
        add(1, 0, 32'h00, 1, 3'd2, 1, 1, 1, 32'hA2);
        add(1, 0, 32'h00, 1, 3'd1, 1, 1, 1, 32'hA3);
        add(1, 0, 32'h00, 1, 3'd0, 0, 1, 0, 32'h00);
        add(1, 0, 32'h00, 1, 3'd0, 0, 1, 0, 32'h00);   // pop on empty ignored
        // 4: count=2 then 8 cycles of simultaneous push/pop, pointers wrap twice
        add(1, 1, 32'h01, 0, 3'd1, 1, 1, 1, 32'h01);
        add(1, 1, 32'h02, 0, 3'd2, 1, 1, 1, 32'h01);
        add(1, 1, 32'h10, 1, 3'd2, 1, 1, 1, 32'h02);
        add(1, 1, 32'h11, 1, 3'd2, 1, 1, 1, 32'h10);
        add(1, 1, 32'h12, 1, 3'd2, 1, 1, 1, 32'h11);
        add(1, 1, 32'h13, 1, 3'd2, 1, 1, 1, 32'h12);
        add(1, 1, 32'h14, 1, 3'd2, 1, 1, 1, 32'h13);
        add(1, 1, 32'h15, 1, 3'd2, 1, 1, 1, 32'h14);
        add(1, 1, 32'h16, 1, 3'd2, 1, 1, 1, 32'h15);
        add(1, 1, 32'h17, 1, 3'd2, 1, 1, 1, 32'h16);
        add(1, 0, 32'h00, 1, 3'd1, 1, 1, 1, 32'h17);
        add(1, 0, 32'h00, 1, 3'd0, 0, 1, 0, 32'h00);
        // 5: full with push and pop offered together
        add(1, 1, 32'hB0, 0, 3'd1, 1, 1, 1, 32'hB0);
        add(1, 1, 32'hB1, 0, 3'd2, 1, 1, 1, 32'hB0);
        add(1, 1, 32'hB2, 0, 3'd3, 1, 1, 1, 32'hB0);
        add(1, 1, 32'hB3, 0, 3'd4, 1, 0, 1, 32'hB0);
        add(1, 1, 32'hB4, 1, 3'd3, 1, 1, 1, 32'hB1);
        // 6: reset at count=3 with a push offered, then fresh push
        add(0, 1, 32'hEE, 1, 3'd0, 0, 1, 0, 32'h00);
        add(1, 0, 32'h00, 0, 3'd0, 0, 1, 0, 32'h00);
        add(1, 1, 32'hC0, 0, 3'd1, 1, 1, 1, 32'hC0);
        add(1, 0, 32'h00, 1, 3'd0, 0, 1, 0, 32'h00);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].iv, vecs[i].d, vecs[i].rdy);
            @(posedge clk);
            #1;
            check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].ia,
                        vecs[i].chk_d, vecs[i].od);
        end

        // Full cycle with pop pending: in_allow must already be low before the edge
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'hD0 + 32'(k), 1'b0);
            @(posedge clk);
            #1;
        end
        check_state("seq_full", 3'd4, 1'b1, 1'b0, 1'b1, 32'hD0);
        drive(1'b1, 1'b1, 32'hDF, 1'b1);
        #1;
        check("seq_full.pre_edge_allow", 32'(bus.in_allow), 32'd0);
        @(posedge clk);
        #1;
        check_state("seq_full_pop", 3'd3, 1'b1, 1'b1, 1'b1, 32'hD1);

        // Bounded drain: remaining words must be D1, D2, D3 and nothing else
        begin
            logic [31:0] exp_q[$];
            int          budget;
            exp_q  = '{32'hD1, 32'hD2, 32'hD3};
            budget = 10;
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            while (bus.out_valid && budget > 0) begin
                if (exp_q.size() == 0) begin
                    check("drain.extra_word", bus.out_data, 32'hFFFF_FFFF);
                    break;
                end
                check("drain.order", bus.out_data, exp_q.pop_front());
                @(posedge clk);
                #1;
                budget--;
            end
            check("drain.budget_ok", 32'(budget > 0), 32'd1);
            check("drain.all_seen", 32'(exp_q.size()), 32'd0);
            check_state("drain.end", 3'd0, 1'b0, 1'b1, 1'b0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
